// File: rtl/hba_pkg.sv
// Shared HBA bus definitions: default widths, slave handshake state encoding
// and the constants used to split the address bus into {periph, reg} fields.
package hba_pkg;

    localparam int HBA_DBUS_WIDTH        = 8;
    localparam int HBA_PERIPH_ADDR_WIDTH = 4;
    localparam int HBA_REG_ADDR_WIDTH    = 8;
    localparam int HBA_ABUS_WIDTH        = HBA_PERIPH_ADDR_WIDTH + HBA_REG_ADDR_WIDTH;

    typedef enum logic [1:0] {
        HBA_ST_IDLE       = 2'd0,
        HBA_ST_ACK        = 2'd1,
        HBA_ST_WAIT_DESEL = 2'd2
    } hba_state_t;

    // The peripheral-select field sits directly above the register field.
    function automatic int hba_periph_lsb(input int reg_addr_width);
        return reg_addr_width;
    endfunction

endpackage

// File: rtl/hba_slave_fsm.sv
// HBA slave select/ack handshake: one-cycle ack one cycle after a hit, then
// waits for the master to drop select; no backpressure, one transfer per select.
module hba_slave_fsm
    import hba_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_select,
    input  logic i_hit,
    output logic o_take,
    output logic o_ack
);

    hba_state_t r_state;
    hba_state_t w_state_nxt;

    // A select still held through reset must not be taken as a fresh transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= i_select ? HBA_ST_WAIT_DESEL : HBA_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_take      = 1'b0;
        o_ack       = 1'b0;
        case (r_state)
            HBA_ST_IDLE: begin
                if (i_hit) begin
                    o_take      = 1'b1;
                    w_state_nxt = HBA_ST_ACK;
                end
            end
            HBA_ST_ACK: begin
                o_ack       = 1'b1;
                w_state_nxt = HBA_ST_WAIT_DESEL;
            end
            HBA_ST_WAIT_DESEL: begin
                if (!i_select) begin
                    w_state_nxt = HBA_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = HBA_ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/hba_reg_bank.sv
// HBA register-bank slave: bus read/write plus per-register core write strobes;
// ack/read data one cycle after select. Optional interrupt under HBA_REG_BANK_INTR_EN.
module hba_reg_bank
    import hba_pkg::*;
#(
    parameter int DBUS_WIDTH        = HBA_DBUS_WIDTH,
    parameter int PERIPH_ADDR_WIDTH = HBA_PERIPH_ADDR_WIDTH,
    parameter int REG_ADDR_WIDTH    = HBA_REG_ADDR_WIDTH,
    parameter int PERIPH_ADDR       = 0,
    parameter int NUM_REGS          = 8
)(
    input  logic                                    hba_clk,
    input  logic                                    hba_reset,
    input  logic                                    hba_select,
    input  logic                                    hba_rnw,
    input  logic [PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] hba_abus,
    input  logic [DBUS_WIDTH-1:0]                   hba_dbus,
    output logic                                    hba_xferack_slave,
    output logic [DBUS_WIDTH-1:0]                   hba_dbus_slave,
    output logic                                    slave_interrupt,
    input  logic [NUM_REGS-1:0]                     core_wr_en,
    input  logic [DBUS_WIDTH-1:0]                   core_wr_data,
    output logic [NUM_REGS*DBUS_WIDTH-1:0]          regs_out
);

    localparam int PERIPH_LSB = hba_periph_lsb(REG_ADDR_WIDTH);

    logic [PERIPH_ADDR_WIDTH-1:0] w_periph;
    logic [REG_ADDR_WIDTH-1:0]    w_reg_addr;
    logic                         w_hit;
    logic                         w_take;
    logic                         w_ack;
    logic [NUM_REGS-1:0]          w_bus_wr_sel;
    logic [DBUS_WIDTH-1:0]        w_rd_val;
    logic [DBUS_WIDTH-1:0]        r_regs [NUM_REGS];
    logic [DBUS_WIDTH-1:0]        r_rdata;

    assign w_periph   = hba_abus[PERIPH_LSB +: PERIPH_ADDR_WIDTH];
    assign w_reg_addr = hba_abus[REG_ADDR_WIDTH-1:0];
    assign w_hit      = hba_select && (w_periph == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));

    hba_slave_fsm u_fsm (
        .i_clk    (hba_clk),
        .i_rst    (hba_reset),
        .i_select (hba_select),
        .i_hit    (w_hit),
        .o_take   (w_take),
        .o_ack    (w_ack)
    );

    // Unimplemented addresses match no register: writes vanish, reads yield 0.
    always_comb begin
        w_bus_wr_sel = '0;
        w_rd_val     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_reg_addr == REG_ADDR_WIDTH'(i)) begin
                w_bus_wr_sel[i] = w_take && !hba_rnw;
                w_rd_val        = r_regs[i];
            end
        end
    end

    // Bus write beats a core strobe to the same register.
    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_bus_wr_sel[i]) begin
                    r_regs[i] <= hba_dbus;
                end else if (core_wr_en[i]) begin
                    r_regs[i] <= core_wr_data;
                end
            end
        end
    end

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            r_rdata <= '0;
        end else if (w_take) begin
            r_rdata <= hba_rnw ? w_rd_val : '0;
        end
    end

    assign hba_xferack_slave = w_ack;
    assign hba_dbus_slave    = w_ack ? r_rdata : '0;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[g*DBUS_WIDTH +: DBUS_WIDTH] = r_regs[g];
    end

`ifdef HBA_REG_BANK_INTR_EN
    logic r_rd_reg0;
    logic r_intr;

    // Set has priority so a strobe landing on the clearing read is not lost.
    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            r_rd_reg0 <= 1'b0;
            r_intr    <= 1'b0;
        end else begin
            if (w_take) begin
                r_rd_reg0 <= hba_rnw && (w_reg_addr == '0);
            end
            if (|core_wr_en) begin
                r_intr <= 1'b1;
            end else if (w_ack && r_rd_reg0) begin
                r_intr <= 1'b0;
            end
        end
    end

    assign slave_interrupt = r_intr;
`else
    assign slave_interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_hba_reg_bank.sv
// Bench for hba_reg_bank at PERIPH_ADDR=2, NUM_REGS=8: table vectors, corner sequences, random traffic.
module tb_hba_reg_bank;

    localparam int NR = 8;

    logic        hba_clk = 1'b0;
    logic        hba_reset;
    logic        hba_select;
    logic        hba_rnw;
    logic [11:0] hba_abus;
    logic [7:0]  hba_dbus;
    logic        hba_xferack_slave;
    logic [7:0]  hba_dbus_slave;
    logic        slave_interrupt;
    logic [7:0]  core_wr_en;
    logic [7:0]  core_wr_data;
    logic [63:0] regs_out;

    always #5 hba_clk = ~hba_clk;

    hba_reg_bank #(
        .DBUS_WIDTH        (8),
        .PERIPH_ADDR_WIDTH (4),
        .REG_ADDR_WIDTH    (8),
        .PERIPH_ADDR       (2),
        .NUM_REGS          (NR)
    ) dut (
        .hba_clk           (hba_clk),
        .hba_reset         (hba_reset),
        .hba_select        (hba_select),
        .hba_rnw           (hba_rnw),
        .hba_abus          (hba_abus),
        .hba_dbus          (hba_dbus),
        .hba_xferack_slave (hba_xferack_slave),
        .hba_dbus_slave    (hba_dbus_slave),
        .slave_interrupt   (slave_interrupt),
        .core_wr_en        (core_wr_en),
        .core_wr_data      (core_wr_data),
        .regs_out          (regs_out)
    );

    typedef struct {
        logic        rnw;
        logic [11:0] addr;
        logic [7:0]  wd;
        int          hold;
        int          exp_acks;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t       tbl [12];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_regs [NR];
    logic       m_intr;

    task automatic step();
        @(posedge hba_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] m_flat();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*8 +: 8] = m_regs[i];
        return v;
    endfunction

    // Reference: slot 2 is ours, regs 0..7 exist, bus beats core, a reg0 read
    // (cleared at the end of its ack) follows any strobe made at the take edge.
    task automatic model_xfer(input logic rnw, input logic [11:0] addr, input logic [7:0] wd,
                              input logic [7:0] mask, input logic [7:0] cd,
                              output int e_ack, output logic [7:0] e_rd);
        logic in_slot;
        int   r;
        in_slot = (addr[11:8] == 4'd2);
        r       = int'(addr[7:0]);
        e_ack   = in_slot ? 1 : 0;
        e_rd    = 8'h00;
        if (in_slot && rnw && r < NR) e_rd = m_regs[r];
        for (int i = 0; i < NR; i++) begin
            if (in_slot && !rnw && r == i) m_regs[i] = wd;
            else if (mask[i])              m_regs[i] = cd;
        end
`ifdef HBA_REG_BANK_INTR_EN
        if (mask != 8'h00) m_intr = 1'b1;
        if (in_slot && rnw && r == 0) m_intr = 1'b0;
`endif
    endtask

    task automatic model_core(input logic [7:0] mask, input logic [7:0] cd);
        for (int i = 0; i < NR; i++) if (mask[i]) m_regs[i] = cd;
`ifdef HBA_REG_BANK_INTR_EN
        if (mask != 8'h00) m_intr = 1'b1;
`endif
    endtask

    task automatic xfer(input logic rnw, input logic [11:0] addr, input logic [7:0] wd,
                        input logic [7:0] mask, input logic [7:0] cd, input int hold,
                        output int acks, output int first, output logic [7:0] rd, output int stray);
        hba_select   = 1'b1;
        hba_rnw      = rnw;
        hba_abus     = addr;
        hba_dbus     = wd;
        core_wr_en   = mask;
        core_wr_data = cd;
        acks = 0; first = 0; rd = 8'h00; stray = 0;
        for (int c = 1; c <= hold + 2; c++) begin
            step();
            if (hba_xferack_slave) begin
                acks++;
                if (first == 0) first = c;
                rd = hba_dbus_slave;
            end else if (hba_dbus_slave != 8'h00) begin
                stray++;
            end
            if (c == 1) core_wr_en = 8'h00;
            if (c == hold) hba_select = 1'b0;
        end
    endtask

    task automatic do_xfer(input string tag, input logic rnw, input logic [11:0] addr,
                           input logic [7:0] wd, input logic [7:0] mask, input logic [7:0] cd,
                           input int hold, input int exp_acks, input logic [7:0] exp_rd);
        int         acks, first, stray;
        logic [7:0] rd;
        xfer(rnw, addr, wd, mask, cd, hold, acks, first, rd, stray);
        chk({tag, "_ack_count"}, 64'(acks), 64'(exp_acks));
        chk({tag, "_ack_cycle"}, 64'(first), 64'(exp_acks));
        chk({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
        chk({tag, "_dbus_outside_ack"}, 64'(stray), 64'd0);
        chk({tag, "_regs"}, regs_out, m_flat());
        chk({tag, "_intr"}, 64'(slave_interrupt), 64'(m_intr));
    endtask

    initial begin
        int         e_ack, acks;
        logic [7:0] e_rd;
        logic       rnw;
        logic [11:0] addr;
        logic [7:0] wd, mask, cd;

        tbl[0]  = '{1'b0, 12'h203, 8'hA5, 3,  1, 8'h00};
        tbl[1]  = '{1'b1, 12'h203, 8'h00, 3,  1, 8'hA5};
        tbl[2]  = '{1'b0, 12'h303, 8'h5A, 3,  0, 8'h00};
        tbl[3]  = '{1'b1, 12'h303, 8'h00, 3,  0, 8'h00};
        tbl[4]  = '{1'b1, 12'h203, 8'h00, 10, 1, 8'hA5};
        tbl[5]  = '{1'b1, 12'h20F, 8'h00, 2,  1, 8'h00};
        tbl[6]  = '{1'b0, 12'h20F, 8'h77, 3,  1, 8'h00};
        tbl[7]  = '{1'b0, 12'h200, 8'h3C, 1,  1, 8'h00};
        tbl[8]  = '{1'b1, 12'h200, 8'h00, 2,  1, 8'h3C};
        tbl[9]  = '{1'b0, 12'h207, 8'hFF, 4,  1, 8'h00};
        tbl[10] = '{1'b1, 12'h207, 8'h00, 2,  1, 8'hFF};
        tbl[11] = '{1'b1, 12'h203, 8'h00, 3,  1, 8'hA5};

        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        m_intr       = 1'b0;
        hba_reset    = 1'b1;
        hba_select   = 1'b0;
        hba_rnw      = 1'b0;
        hba_abus     = '0;
        hba_dbus     = '0;
        core_wr_en   = '0;
        core_wr_data = '0;
        step();
        step();
        chk("reset_ack", 64'(hba_xferack_slave), 64'd0);
        chk("reset_dbus", 64'(hba_dbus_slave), 64'd0);
        chk("reset_intr", 64'(slave_interrupt), 64'd0);
        chk("reset_regs", regs_out, 64'd0);
        hba_reset = 1'b0;
        step();

        for (int i = 0; i < 12; i++) begin
            model_xfer(tbl[i].rnw, tbl[i].addr, tbl[i].wd, 8'h00, 8'h00, e_ack, e_rd);
            do_xfer($sformatf("tbl%0d", i), tbl[i].rnw, tbl[i].addr, tbl[i].wd, 8'h00, 8'h00,
                    tbl[i].hold, tbl[i].exp_acks, tbl[i].exp_rd);
        end

        // Bus write and core strobe hit reg1 on the same edge.
        model_xfer(1'b0, 12'h201, 8'h11, 8'h02, 8'h22, e_ack, e_rd);
        do_xfer("collide", 1'b0, 12'h201, 8'h11, 8'h02, 8'h22, 3, 1, 8'h00);
        chk("collide_reg1", 64'(regs_out[15:8]), 64'h11);

        // Core strobe alone, then a reg0 read clears the interrupt.
        core_wr_en = 8'h10; core_wr_data = 8'h99;
        step();
        core_wr_en = 8'h00;
        model_core(8'h10, 8'h99);
        chk("core_reg4", 64'(regs_out[39:32]), 64'h99);
        chk("core_intr", 64'(slave_interrupt), 64'(m_intr));
        model_xfer(1'b1, 12'h200, 8'h00, 8'h00, 8'h00, e_ack, e_rd);
        do_xfer("intr_clear", 1'b1, 12'h200, 8'h00, 8'h00, 8'h00, 2, 1, e_rd);

        // Strobe during the ack of a reg0 read: set beats clear.
        hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = 12'h200;
        step();
        chk("setwins_ack", 64'(hba_xferack_slave), 64'd1);
        core_wr_en = 8'h01; core_wr_data = 8'h05;
        step();
        core_wr_en = 8'h00; hba_select = 1'b0;
        m_regs[0] = 8'h05;
`ifdef HBA_REG_BANK_INTR_EN
        m_intr = 1'b1;
`endif
        step();
        step();
        chk("setwins_intr", 64'(slave_interrupt), 64'(m_intr));
        chk("setwins_regs", regs_out, m_flat());

        // Reset in the ack cycle with select still held.
        hba_select = 1'b1; hba_rnw = 1'b1; hba_abus = 12'h203;
        step();
        chk("rstmid_ack", 64'(hba_xferack_slave), 64'd1);
        chk("rstmid_dbus", 64'(hba_dbus_slave), 64'(m_regs[3]));
        hba_reset = 1'b1;
        step();
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        m_intr = 1'b0;
        chk("rstmid_ack_after", 64'(hba_xferack_slave), 64'd0);
        chk("rstmid_dbus_after", 64'(hba_dbus_slave), 64'd0);
        chk("rstmid_regs_after", regs_out, 64'd0);
        chk("rstmid_intr_after", 64'(slave_interrupt), 64'd0);
        hba_reset = 1'b0;
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (hba_xferack_slave) acks++;
        end
        chk("rstmid_held_no_ack", 64'(acks), 64'd0);
        hba_select = 1'b0;
        step();
        model_xfer(1'b1, 12'h203, 8'h00, 8'h00, 8'h00, e_ack, e_rd);
        do_xfer("rstmid_reselect", 1'b1, 12'h203, 8'h00, 8'h00, 8'h00, 2, 1, 8'h00);

        for (int n = 0; n < 150; n++) begin
            mask = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            cd   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                core_wr_en = mask; core_wr_data = cd;
                step();
                core_wr_en = 8'h00;
                model_core(mask, cd);
                chk($sformatf("rnd%0d_core_regs", n), regs_out, m_flat());
                chk($sformatf("rnd%0d_core_intr", n), 64'(slave_interrupt), 64'(m_intr));
            end else begin
                rnw  = 1'($urandom_range(0, 1));
                addr = {(($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd2),
                        8'($urandom_range(0, 11))};
                wd   = 8'($urandom_range(0, 255));
                model_xfer(rnw, addr, wd, mask, cd, e_ack, e_rd);
                do_xfer($sformatf("rnd%0d", n), rnw, addr, wd, mask, cd,
                        $urandom_range(1, 4), e_ack, e_rd);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hba_reg_bank.md
HBA_REG_BANK -- requirements
Module: hba_reg_bank

Interface
REQ-001 SHALL have parameter DBUS_WIDTH, default 8, meaning data bus width.
REQ-002 SHALL have parameter PERIPH_ADDR_WIDTH, default 4, meaning peripheral-select field width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 8, meaning register-address field width.
REQ-004 SHALL have parameter PERIPH_ADDR, default 0, meaning this slave's peripheral slot.
REQ-005 SHALL have parameter NUM_REGS, default 8, range 1..256, meaning implemented register count.
REQ-006 SHALL have port hba_clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-007 SHALL have port hba_reset, input, 1, meaning reset; it is synchronous and active-high.
REQ-008 SHALL have port hba_select, input, 1, meaning a master transfer is in progress.
REQ-009 SHALL have port hba_rnw, input, 1, meaning 1 = read, 0 = write.
REQ-010 SHALL have port hba_abus, input, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH, meaning {periph, reg} address.
REQ-011 SHALL have port hba_dbus, input, DBUS_WIDTH, meaning master write data.
REQ-012 SHALL have port hba_xferack_slave, output, 1, meaning transfer complete; ORed with the other slaves' acks.
REQ-013 SHALL have port hba_dbus_slave, output, DBUS_WIDTH, meaning read data; ORed onto the bus.
REQ-014 SHALL have port slave_interrupt, output, 1, meaning interrupt request.
REQ-015 SHALL have port core_wr_en, input, NUM_REGS, meaning per-register core-side write strobe.
REQ-016 SHALL have port core_wr_data, input, DBUS_WIDTH, meaning core-side write data.
REQ-017 SHALL have port regs_out, output, NUM_REGS*DBUS_WIDTH, meaning flattened register contents; reg0 is in the LSBs.

Function
REQ-018 SHALL select this slave when hba_select=1 and hba_abus[upper PERIPH_ADDR_WIDTH bits] == PERIPH_ADDR.
REQ-019 SHALL implement the FSM IDLE, ACK, WAIT_DESEL.
- IDLE to ACK: on the selected condition.
- ACK to WAIT_DESEL: unconditional.
- WAIT_DESEL to IDLE: when hba_select=0.
REQ-020 SHALL assert hba_xferack_slave only while in ACK.
- The ack lasts exactly one cycle and comes one cycle after select is first sampled.
REQ-021 SHALL, on a selected write, load hba_dbus into the addressed register at the IDLE to ACK edge.
- The new value is visible on regs_out in the ACK cycle.
REQ-022 SHALL, on a selected read, register the addressed register's value at the IDLE to ACK edge.
- The value is driven on hba_dbus_slave during ACK only.
REQ-023 SHALL drive hba_dbus_slave = 0 in every state other than ACK and when not selected.
REQ-024 SHALL handle a register address >= NUM_REGS as follows: writes are ignored, reads return 0, and the transfer is still acked.
REQ-025 SHALL perform at most one transfer per select assertion; a held hba_select does not re-trigger until it has been deasserted.
REQ-026 SHALL let a core_wr_en[i] strobe load core_wr_data into reg i in the same edge, in any state.
REQ-027 SHALL resolve a bus write and a core write to the same register in the same cycle in favour of the bus; the core write is dropped.
REQ-028 SHALL ignore all transfers addressed to other PERIPH_ADDR values (no ack, dbus 0, no register change).

Reset
REQ-029 SHALL, while hba_reset=1, return the FSM to IDLE.
REQ-030 SHALL, while hba_reset=1, clear all registers, hba_xferack_slave, hba_dbus_slave and slave_interrupt to 0 at the next edge.
REQ-031 SHALL abort a transfer in progress when reset is asserted mid-transfer, with no ack issued.
REQ-032 SHALL, after reset, wait for hba_select=0 before accepting a new transfer.
- This means treating reset as entering WAIT_DESEL when hba_select=1.

Configuration
REQ-033 SHALL, with HBA_REG_BANK_INTR_EN defined, set slave_interrupt on any core_wr_en strobe.
- It clears on an acked bus read of reg 0.
- If the set and the clear fall in the same cycle, the set wins.
REQ-034 SHALL, without HBA_REG_BANK_INTR_EN, tie slave_interrupt to constant 0 and instantiate no interrupt logic.

Structure
REQ-035 SHALL take the default bus widths, the FSM state encoding, and the address-split helper constants from the shared package hba_pkg.
REQ-036 SHALL place the select/ack handshake FSM (REQ-019, 020, 025, 032) in the sub-module hba_slave_fsm, reusable by other peripherals.

Verification
REQ-037 SHALL cover: PERIPH_ADDR=2; write abus=0x203, dbus=0xA5 -> ack one cycle later for 1 cycle; regs_out reg3 = 0xA5.
REQ-038 SHALL cover: read abus=0x203 after REQ-037 -> hba_dbus_slave = 0xA5 exactly in the ack cycle, 0 otherwise.
REQ-039 SHALL cover: write abus=0x303 (other slot) -> no ack, dbus_slave stays 0, regs unchanged.
REQ-040 SHALL cover: select held for 10 cycles on a read -> exactly one ack; read abus=0x20F (NUM_REGS=8) -> ack with data 0x00.
REQ-041 SHALL cover: same-cycle bus write 0x11 and core_wr_en[1] with 0x22 to reg1 -> reg1 = 0x11.
REQ-042 SHALL cover: with HBA_REG_BANK_INTR_EN, core_wr_en[4] -> slave_interrupt=1; read abus=0x200 -> interrupt 0 after ack.
REQ-043 SHALL cover: reset asserted during the ACK cycle -> outputs 0 next edge; no ack until select drops and is re-asserted.
